survivor_ram: RTL and testbench

Parametrised single-clock survivor-path memory for the Viterbi decoder, successor to the fixed 8-bit dual-clock RAM. It stores one decision word per cycle in a circular buffer and serves both random-access reads and an autonomous traceback read mode. Traceback walks backwards from the newest word, one word per cycle. It sits between the ACS/decision stage (writer) and the traceback/output logic (reader) and replaces the bidirectional-bus RAM with separate in/out data ports.

---
 rtl/survivor_ram.sv | 134 +++++++++++++
 tb/tb_survivor_ram.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/survivor_ram.sv
// Survivor-path memory for the Viterbi decoder: a circular decision-word buffer
// with single-cycle random reads and an autonomous newest-to-oldest traceback.
`ifndef WD_RAM_ADDRESS
`define WD_RAM_ADDRESS 4
`endif

module survivor_ram #(
  parameter int unsigned WD_DATA = 8,
  parameter int unsigned WD_ADDR = `WD_RAM_ADDRESS
) (
  input  logic               Clock,
  input  logic               Reset,
  input  logic               WriteEnable,
  input  logic [WD_DATA-1:0] DataIn,
  input  logic               RandomRead,
  input  logic [WD_ADDR-1:0] ReadAddress,
  input  logic               TraceStart,
  input  logic [WD_ADDR:0]   TraceLength,
  output logic [WD_DATA-1:0] DataOut,
  output logic               DataValid,
  output logic               TraceLast,
  output logic               Busy,
  output logic [WD_ADDR:0]   Count,
  output logic               Full
);

  localparam int unsigned WD_CNT = WD_ADDR + 1;
  localparam int unsigned DEPTH  = 1 << WD_ADDR;

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] TRACE = 1'b1;

  logic [WD_DATA-1:0] mem [DEPTH];

  logic [0:0]         state, state_n;
  logic [WD_ADDR-1:0] wr_ptr;
  logic [WD_ADDR-1:0] addr, addr_n;
  logic [WD_CNT-1:0]  remaining, remaining_n;
  logic [WD_CNT-1:0]  count_q;
  logic               full_q;
  logic [WD_DATA-1:0] dout_n;
  logic               valid_n, last_n;
  logic [WD_ADDR-1:0] rd_addr;
  logic [WD_CNT-1:0]  eff_len;
  logic               trace_go;

  // Decision storage; read is taken from the pre-edge contents (read-before-write).
  always_ff @(posedge Clock) begin
    if (WriteEnable) mem[wr_ptr] <= DataIn;
  end

  // Write pointer and fill level; writes are accepted in every state.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      wr_ptr  <= '0;
      count_q <= '0;
      full_q  <= 1'b0;
    end else if (WriteEnable) begin
      wr_ptr <= wr_ptr + WD_ADDR'(1);
      if (count_q != WD_CNT'(DEPTH)) begin
        count_q <= count_q + WD_CNT'(1);
        full_q  <= (count_q + WD_CNT'(1)) == WD_CNT'(DEPTH);
      end
    end
  end

  // Clamp the requested trace length to the number of stored words.
  always_comb begin
    eff_len  = (TraceLength < count_q) ? TraceLength : count_q;
    trace_go = TraceStart && (TraceLength != '0) && (count_q != '0);
  end

  // Next-state and registered-output decode.
  always_comb begin
    state_n     = state;
    addr_n      = addr;
    remaining_n = remaining;
    valid_n     = 1'b0;
    last_n      = 1'b0;
    rd_addr     = ReadAddress;
    dout_n      = DataOut;
    case (state)
      IDLE: begin
        if (trace_go) begin
          rd_addr     = wr_ptr - WD_ADDR'(1);
          valid_n     = 1'b1;
          last_n      = (eff_len == WD_CNT'(1));
          addr_n      = wr_ptr - WD_ADDR'(2);
          remaining_n = eff_len - WD_CNT'(1);
          if (eff_len > WD_CNT'(1)) state_n = TRACE;
        end else if (RandomRead) begin
          rd_addr = ReadAddress;
          valid_n = 1'b1;
        end
      end
      TRACE: begin
        rd_addr     = addr;
        valid_n     = 1'b1;
        addr_n      = addr - WD_ADDR'(1);
        remaining_n = remaining - WD_CNT'(1);
        if (remaining == WD_CNT'(1)) begin
          last_n  = 1'b1;
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
    if (valid_n) dout_n = mem[rd_addr];
  end

  // State and output registers; reset aborts any traceback in flight.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state     <= IDLE;
      addr      <= '0;
      remaining <= '0;
      DataOut   <= '0;
      DataValid <= 1'b0;
      TraceLast <= 1'b0;
    end else begin
      state     <= state_n;
      addr      <= addr_n;
      remaining <= remaining_n;
      DataOut   <= dout_n;
      DataValid <= valid_n;
      TraceLast <= last_n;
    end
  end

  assign Busy  = (state == TRACE);
  assign Count = count_q;
  assign Full  = full_q;

endmodule

// File: tb/tb_survivor_ram.sv
// Directed bench for survivor_ram with a 4-deep, 8-bit configuration.
module tb_survivor_ram;

  logic       Clock = 1'b0;
  logic       Reset = 1'b0;
  logic       WriteEnable = 1'b0;
  logic [7:0] DataIn = '0;
  logic       RandomRead = 1'b0;
  logic [1:0] ReadAddress = '0;
  logic       TraceStart = 1'b0;
  logic [2:0] TraceLength = '0;
  logic [7:0] DataOut;
  logic       DataValid, TraceLast, Busy, Full;
  logic [2:0] Count;

  int total = 0;
  int bad = 0;

  survivor_ram #(.WD_DATA(8), .WD_ADDR(2)) dut (
    .Clock(Clock), .Reset(Reset), .WriteEnable(WriteEnable), .DataIn(DataIn),
    .RandomRead(RandomRead), .ReadAddress(ReadAddress), .TraceStart(TraceStart),
    .TraceLength(TraceLength), .DataOut(DataOut), .DataValid(DataValid),
    .TraceLast(TraceLast), .Busy(Busy), .Count(Count), .Full(Full)
  );

  always #5 Clock = ~Clock;

  // Advance one edge and settle just after it.
  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  task automatic quiet();
    WriteEnable = 1'b0; RandomRead = 1'b0; TraceStart = 1'b0;
  endtask

  task automatic do_reset();
    quiet();
    Reset = 1'b0;
    tick();
    Reset = 1'b1;
  endtask

  task automatic write_word(input logic [7:0] d);
    WriteEnable = 1'b1; DataIn = d;
    tick();
    WriteEnable = 1'b0;
  endtask

  task automatic test_reset();
    quiet();
    Reset = 1'b0;
    #3;
    total++;
    if ({DataOut, DataValid, TraceLast, Busy, Count, Full} !== 15'h0) begin
      bad++; $display("FAIL reset_outputs: got dout=%h v=%b l=%b b=%b c=%0d f=%b want all 0",
                      DataOut, DataValid, TraceLast, Busy, Count, Full);
    end
    tick();
    Reset = 1'b1;
    repeat (3) tick();
    total++;
    if (Count !== 3'd0 || Full !== 1'b0) begin
      bad++; $display("FAIL idle_count: got c=%0d f=%b want 0/0", Count, Full);
    end
  endtask

  task automatic test_random_read();
    do_reset();
    write_word(8'hA5);
    write_word(8'h3C);
    total++;
    if (Count !== 3'd2 || Full !== 1'b0) begin
      bad++; $display("FAIL rr_count: got c=%0d f=%b want 2/0", Count, Full);
    end
    RandomRead = 1'b1; ReadAddress = 2'd0;
    tick();
    total++;
    if (DataOut !== 8'hA5 || DataValid !== 1'b1 || TraceLast !== 1'b0) begin
      bad++; $display("FAIL rr_addr0: got %h v=%b l=%b want a5 v=1 l=0", DataOut, DataValid, TraceLast);
    end
    ReadAddress = 2'd1;
    tick();
    total++;
    if (DataOut !== 8'h3C || DataValid !== 1'b1) begin
      bad++; $display("FAIL rr_addr1: got %h v=%b want 3c v=1", DataOut, DataValid);
    end
    RandomRead = 1'b0;
    tick();
    total++;
    if (DataOut !== 8'h3C || DataValid !== 1'b0) begin
      bad++; $display("FAIL rr_hold: got %h v=%b want 3c v=0", DataOut, DataValid);
    end
  endtask

  task automatic test_trace_wrap();
    logic [7:0] exp_d [4] = '{8'h05, 8'h04, 8'h03, 8'h02};
    logic       exp_b [4] = '{1'b1, 1'b1, 1'b1, 1'b0};
    do_reset();
    for (int i = 1; i <= 5; i++) write_word(8'(i));
    total++;
    if (Count !== 3'd4 || Full !== 1'b1) begin
      bad++; $display("FAIL wrap_count: got c=%0d f=%b want 4/1", Count, Full);
    end
    TraceStart = 1'b1; TraceLength = 3'd4;
    for (int i = 0; i < 4; i++) begin
      tick();
      TraceStart = 1'b0;
      total++;
      if (DataOut !== exp_d[i] || DataValid !== 1'b1 || TraceLast !== (i == 3) || Busy !== exp_b[i]) begin
        bad++; $display("FAIL wrap_trace[%0d]: got %h v=%b l=%b b=%b want %h v=1 l=%b b=%b",
                        i, DataOut, DataValid, TraceLast, Busy, exp_d[i], (i == 3), exp_b[i]);
      end
    end
    tick();
    total++;
    if (DataValid !== 1'b0 || TraceLast !== 1'b0 || Busy !== 1'b0) begin
      bad++; $display("FAIL wrap_after: got v=%b l=%b b=%b want 0/0/0", DataValid, TraceLast, Busy);
    end
  endtask

  task automatic test_clamp();
    do_reset();
    write_word(8'hAA);
    write_word(8'hBB);
    TraceStart = 1'b1; TraceLength = 3'd7;
    tick();
    TraceStart = 1'b0;
    total++;
    if (DataOut !== 8'hBB || DataValid !== 1'b1 || TraceLast !== 1'b0 || Busy !== 1'b1) begin
      bad++; $display("FAIL clamp_w0: got %h v=%b l=%b b=%b want bb 1 0 1", DataOut, DataValid, TraceLast, Busy);
    end
    tick();
    total++;
    if (DataOut !== 8'hAA || DataValid !== 1'b1 || TraceLast !== 1'b1 || Busy !== 1'b0) begin
      bad++; $display("FAIL clamp_w1: got %h v=%b l=%b b=%b want aa 1 1 0", DataOut, DataValid, TraceLast, Busy);
    end
    TraceStart = 1'b1; TraceLength = 3'd0;
    tick();
    TraceStart = 1'b0;
    total++;
    if (DataValid !== 1'b0 || Busy !== 1'b0 || DataOut !== 8'hAA) begin
      bad++; $display("FAIL len_zero: got %h v=%b b=%b want aa v=0 b=0", DataOut, DataValid, Busy);
    end
  endtask

  task automatic test_busy_ignore();
    do_reset();
    write_word(8'h11); write_word(8'h22); write_word(8'h33); write_word(8'h44);
    TraceStart = 1'b1; TraceLength = 3'd3;
    tick();
    total++;
    if (DataOut !== 8'h44 || Busy !== 1'b1) begin
      bad++; $display("FAIL busy_w0: got %h b=%b want 44 b=1", DataOut, Busy);
    end
    TraceLength = 3'd4; RandomRead = 1'b1; ReadAddress = 2'd0;
    tick();
    total++;
    if (DataOut !== 8'h33 || TraceLast !== 1'b0 || Busy !== 1'b1) begin
      bad++; $display("FAIL busy_w1: got %h l=%b b=%b want 33 l=0 b=1", DataOut, TraceLast, Busy);
    end
    tick();
    quiet();
    total++;
    if (DataOut !== 8'h22 || TraceLast !== 1'b1 || Busy !== 1'b0) begin
      bad++; $display("FAIL busy_w2: got %h l=%b b=%b want 22 l=1 b=0", DataOut, TraceLast, Busy);
    end
    TraceStart = 1'b1; TraceLength = 3'd1; RandomRead = 1'b1; ReadAddress = 2'd0;
    tick();
    quiet();
    total++;
    if (DataOut !== 8'h44 || DataValid !== 1'b1 || TraceLast !== 1'b1 || Busy !== 1'b0) begin
      bad++; $display("FAIL priority: got %h v=%b l=%b b=%b want 44 1 1 0", DataOut, DataValid, TraceLast, Busy);
    end
  endtask

  task automatic test_collision();
    logic [7:0] exp_d [4] = '{8'h44, 8'h33, 8'h22, 8'h11};
    do_reset();
    write_word(8'h11); write_word(8'h22); write_word(8'h33); write_word(8'h44);
    TraceStart = 1'b1; TraceLength = 3'd4;
    for (int i = 0; i < 4; i++) begin
      if (i == 3) begin WriteEnable = 1'b1; DataIn = 8'h99; end
      tick();
      quiet();
      total++;
      if (DataOut !== exp_d[i] || DataValid !== 1'b1) begin
        bad++; $display("FAIL collide[%0d]: got %h v=%b want %h v=1", i, DataOut, DataValid, exp_d[i]);
      end
    end
    RandomRead = 1'b1; ReadAddress = 2'd0;
    tick();
    quiet();
    total++;
    if (DataOut !== 8'h99 || DataValid !== 1'b1) begin
      bad++; $display("FAIL collide_newdata: got %h v=%b want 99 v=1", DataOut, DataValid);
    end
  endtask

  task automatic test_reset_mid_trace();
    do_reset();
    write_word(8'h11); write_word(8'h22); write_word(8'h33); write_word(8'h44);
    TraceStart = 1'b1; TraceLength = 3'd4;
    tick();
    TraceStart = 1'b0;
    tick();
    total++;
    if (DataOut !== 8'h33 || Busy !== 1'b1) begin
      bad++; $display("FAIL mid_pre: got %h b=%b want 33 b=1", DataOut, Busy);
    end
    #1 Reset = 1'b0;
    #1;
    total++;
    if ({DataOut, DataValid, TraceLast, Busy, Count, Full} !== 15'h0) begin
      bad++; $display("FAIL mid_reset: got dout=%h v=%b l=%b b=%b c=%0d f=%b want all 0",
                      DataOut, DataValid, TraceLast, Busy, Count, Full);
    end
    tick();
    Reset = 1'b1;
    TraceStart = 1'b1; TraceLength = 3'd4;
    tick();
    quiet();
    total++;
    if (DataValid !== 1'b0 || Busy !== 1'b0 || Count !== 3'd0) begin
      bad++; $display("FAIL empty_start: got v=%b b=%b c=%0d want 0 0 0", DataValid, Busy, Count);
    end
  endtask

  initial begin
    test_reset();
    test_random_read();
    test_trace_wrap();
    test_clamp();
    test_busy_ignore();
    test_collision();
    test_reset_mid_trace();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
